// File: rtl/cselecta_m_n_pkg.sv
// cselecta_m_n_pkg: parameter legality helper shared by the carry-select adder files.
`default_nettype none

package cselecta_m_n_pkg;

  function automatic bit cs_params_ok(input int m, input int n);
    return (m >= 1) && (n >= 1) && (n <= m) && ((m % n) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cselecta_m_n_rca_n.sv
// rca_n: N-bit ripple-carry adder built from a generated chain of full adders.
`default_nettype none

module rca_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

`default_nettype wire

// File: rtl/cselecta_m_n.sv
// cselecta_m_n: M-bit carry-select adder in N-bit slices, {Cout, Sum} registered once.
`default_nettype none

module cselecta_m_n
  import cselecta_m_n_pkg::*;
#(
  parameter int M = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] Sum,
  output logic         Cout
);

  localparam int NSLICE = M / N;

  if (!cs_params_ok(M, N)) begin : g_bad_params
    $error("cselecta_m_n: illegal M=%0d N=%0d (need 1<=N<=M, M%%N==0)", M, N);
  end

  logic [NSLICE-1:0] c;
  logic [M-1:0]      sum_d;
  logic              cout_d;
  logic [M-1:0]      sum_q;
  logic              cout_q;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    if (k == 0) begin : g_first
      rca_n #(.N(N)) u_rca (
        .a   (A[N-1:0]),
        .b   (B[N-1:0]),
        .cin (1'b0),
        .s   (sum_d[N-1:0]),
        .cout(c[0])
      );
    end else begin : g_sel
      logic [N-1:0] s0;
      logic [N-1:0] s1;
      logic         co0;
      logic         co1;

      rca_n #(.N(N)) u_rca0 (
        .a   (A[k*N +: N]),
        .b   (B[k*N +: N]),
        .cin (1'b0),
        .s   (s0),
        .cout(co0)
      );

      rca_n #(.N(N)) u_rca1 (
        .a   (A[k*N +: N]),
        .b   (B[k*N +: N]),
        .cin (1'b1),
        .s   (s1),
        .cout(co1)
      );

      // Incoming carry only steers muxes; it never ripples through this slice.
      assign sum_d[k*N +: N] = c[k-1] ? s1 : s0;
      assign c[k]            = c[k-1] ? co1 : co0;
    end
  end

  assign cout_d = c[NSLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cselecta_m_n.sv
// tb_cselecta_m_n: directed and random checks of cselecta_m_n at (32,4), (8,8) and (12,3).
`default_nettype none

module tb_cselecta_m_n;

  logic        clk;
  logic        rst_n;
  logic [31:0] a32, b32;
  logic [31:0] sum32;
  logic        cout32;
  logic [7:0]  a8, b8, sum8;
  logic        cout8;
  logic [11:0] a12, b12, sum12;
  logic        cout12;

  int checks = 0;
  int errors = 0;

  cselecta_m_n #(.M(32), .N(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .Sum(sum32), .Cout(cout32)
  );
  cselecta_m_n #(.M(8), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Sum(sum8), .Cout(cout8)
  );
  cselecta_m_n #(.M(12), .N(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .A(a12), .B(b12), .Sum(sum12), .Cout(cout12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive new inputs just after a rising edge, then check the result just after the next one.
  task automatic step32(input logic [31:0] a, input logic [31:0] b, input string tag,
                        input logic [32:0] exp);
    a32 = a;
    b32 = b;
    @(posedge clk);
    #1;
    check(tag, {cout32, sum32}, exp);
  endtask

  logic [32:0] exp32_prev;
  logic [8:0]  exp8_prev;
  logic [12:0] exp12_prev;

  initial begin
    rst_n = 1'b0;
    a32 = 32'hFFFF_FFFF; b32 = 32'h1;
    a8 = '0; b8 = '0; a12 = '0; b12 = '0;

    // 1: outputs held at zero through reset, then FFFFFFFF+1 after release
    #2;
    check("rst_async_initial", {cout32, sum32}, 33'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", {cout32, sum32}, 33'h0);
    check("rst_held_m8", {24'h0, cout8, sum8}, 33'h0);
    check("rst_held_m12", {20'h0, cout12, sum12}, 33'h0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ffffffff_plus_1", {cout32, sum32}, {1'b1, 32'h0000_0000});

    // 2: carry crossing a slice boundary
    step32(32'h0000_000F, 32'h0000_0001, "slice_carry_0f_01", {1'b0, 32'h0000_0010});
    // 3: no-carry-out max and pure carry-out
    step32(32'h7FFF_FFFF, 32'h7FFF_FFFF, "7fff_plus_7fff", {1'b0, 32'hFFFF_FFFE});
    step32(32'h8000_0000, 32'h8000_0000, "8000_plus_8000", {1'b1, 32'h0000_0000});
    step32(32'h1234_5678, 32'h8765_4321, "mixed_pattern", {1'b0, 32'h9999_9999});
    step32(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones", {1'b1, 32'hFFFF_FFFE});

    // 4: back-to-back, result must not appear before its edge
    a32 = 32'd100; b32 = 32'd200;
    #1;
    check("latency_before_edge", {cout32, sum32}, {1'b1, 32'hFFFF_FFFE});
    @(posedge clk);
    #1;
    check("pipe_300", {cout32, sum32}, 33'd300);
    a32 = 32'd0; b32 = 32'd0;
    #1;
    check("pipe_hold_300", {cout32, sum32}, 33'd300);
    @(posedge clk);
    #1;
    check("pipe_0", {cout32, sum32}, 33'd0);

    // 5: random regression on all three configurations
    a32 = $urandom; b32 = $urandom;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a12 = 12'($urandom); b12 = 12'($urandom);
    exp32_prev = {1'b0, a32} + {1'b0, b32};
    exp8_prev  = {1'b0, a8} + {1'b0, b8};
    exp12_prev = {1'b0, a12} + {1'b0, b12};
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      check("rand_m32_n4", {cout32, sum32}, exp32_prev);
      check("rand_m8_n8", {24'h0, cout8, sum8}, {24'h0, exp8_prev});
      check("rand_m12_n3", {20'h0, cout12, sum12}, {20'h0, exp12_prev});
      a32 = $urandom; b32 = $urandom;
      a8 = 8'($urandom); b8 = 8'($urandom);
      a12 = 12'($urandom); b12 = 12'($urandom);
      exp32_prev = {1'b0, a32} + {1'b0, b32};
      exp8_prev  = {1'b0, a8} + {1'b0, b8};
      exp12_prev = {1'b0, a12} + {1'b0, b12};
    end

    // 6: asynchronous reset mid-stream
    @(posedge clk);
    #1;
    check("stream_before_rst", {cout32, sum32}, exp32_prev);
    a32 = 32'h0000_0005; b32 = 32'h0000_0007;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_drop", {cout32, sum32}, 33'h0);
    check("async_rst_drop_m8", {24'h0, cout8, sum8}, 33'h0);
    check("async_rst_drop_m12", {20'h0, cout12, sum12}, 33'h0);
    @(posedge clk);
    #1;
    check("async_rst_held_edge", {cout32, sum32}, 33'h0);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_release_before_edge", {cout32, sum32}, 33'h0);
    @(posedge clk);
    #1;
    check("rst_release_first_result", {cout32, sum32}, 33'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
